frame_tile_scheduler: RTL and testbench

//  Schedules redraws of the 32x24 tile framebuffer behind the histogram/game pixel logic.

---
 rtl/frame_tile_scheduler_if.sv | 38 +++
 rtl/frame_tile_scheduler.sv | 145 ++++++++++++++
 tb/tb_frame_tile_scheduler.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_tile_scheduler_if.sv
// Bus between the tile scheduler, the combinational pixel generator and the tile RAMs.
//
// Handshake: there is no backpressure. bins_valid and frame_start are one-cycle
// request pulses with no ready. wr_en is a one-cycle valid strobe that qualifies
// wr_addr/wr_data, and the RAM must accept it in that cycle. pixel_in is a
// combinational response to x/y within the same cycle. dbg_state mirrors the
// scheduler FSM so that checkers can bind to it.
interface frame_tile_scheduler_if #(
  parameter int ADDR_W = 10
);
  logic              bins_valid;
  logic              frame_start;
  logic [7:0]        pixel_in;
  logic [9:0]        x_coord_of_current_block;
  logic [9:0]        y_coord_of_current_block;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              whichRAM;
  logic              move_tick;
  logic              busy;
  logic              overrun;
  logic [1:0]        dbg_state;

  // Environment side: request pulses, pixel generator and RAM sink.
  modport master (
    output bins_valid, frame_start, pixel_in,
    input  x_coord_of_current_block, y_coord_of_current_block,
    input  wr_en, wr_addr, wr_data, whichRAM, move_tick, busy, overrun, dbg_state
  );

  // Scheduler side.
  modport slave (
    input  bins_valid, frame_start, pixel_in,
    output x_coord_of_current_block, y_coord_of_current_block,
    output wr_en, wr_addr, wr_data, whichRAM, move_tick, busy, overrun, dbg_state
  );
endinterface

// File: rtl/frame_tile_scheduler.sv
// frame_tile_scheduler: walks the GRID_W x GRID_H tile grid through the pixel
// generator, writes each pixel byte into the back tile RAM, and flips the
// front/back RAM select only at a display frame boundary. It also emits a
// free-running movement tick.
// Optional feature macro: FRAME_TILE_SCHED_AUTO_REFRESH_EN. When it is defined,
// frame_start seen in IDLE also starts a redraw.
module frame_tile_scheduler #(
  parameter int GRID_W        = 32,
  parameter int GRID_H        = 24,
  parameter int ADDR_W        = 10,
  parameter int MOVE_DIV_BITS = 20
) (
  input logic                   clk,
  input logic                   reset,
  frame_tile_scheduler_if.slave bus
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SCAN      = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

  logic [1:0]               r_state;
  logic                     r_drain;     // last coordinate issued; SCAN holds for its write
  logic [9:0]               r_x;
  logic [9:0]               r_y;
  logic                     r_pending;
  logic                     r_overrun;
  logic                     r_which;
  logic                     r_wr_en;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic [7:0]               r_wr_data;
  logic [MOVE_DIV_BITS-1:0] r_div;
  logic                     r_move_tick;

  logic              w_idle_req;
  logic              w_x_last;
  logic              w_y_last;
  logic              w_write_slot;
  logic [ADDR_W-1:0] w_addr;

`ifdef FRAME_TILE_SCHED_AUTO_REFRESH_EN
  assign w_idle_req = bus.bins_valid | bus.frame_start | r_pending;
`else
  assign w_idle_req = bus.bins_valid | r_pending;
`endif

  assign w_x_last     = (r_x == 10'(GRID_W - 1));
  assign w_y_last     = (r_y == 10'(GRID_H - 1));
  assign w_write_slot = (r_state == ST_SCAN) && !r_drain;
  assign w_addr       = ADDR_W'(32'(r_y) * 32'(GRID_W) + 32'(r_x));

  // Scheduler FSM: request queueing, coordinate stepping and RAM swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_drain   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_which   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_idle_req) begin
            r_state   <= ST_SCAN;
            r_pending <= 1'b0;
            r_drain   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
          end
        end
        ST_SCAN: begin
          if (bus.bins_valid) begin
            if (r_pending) r_overrun <= 1'b1;
            else           r_pending <= 1'b1;
          end
          if (r_drain) begin
            // The final write is on the bus this cycle, so the scan is complete.
            r_state <= ST_WAIT_SWAP;
            r_drain <= 1'b0;
          end else if (w_x_last) begin
            if (w_y_last) begin
              r_drain <= 1'b1;   // hold x/y at the last tile
            end else begin
              r_x <= '0;
              r_y <= r_y + 10'd1;
            end
          end else begin
            r_x <= r_x + 10'd1;
          end
        end
        ST_WAIT_SWAP: begin
          if (bus.bins_valid) begin
            if (r_pending) r_overrun <= 1'b1;
            else           r_pending <= 1'b1;
          end
          if (bus.frame_start) begin
            r_which <= ~r_which;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-cycle write pipeline: register the address and pixel for the coordinate presented now.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_write_slot;
      if (w_write_slot) begin
        r_wr_addr <= w_addr;
        r_wr_data <= bus.pixel_in;
      end
    end
  end

  // Free-running movement divider; the tick marks the cycle after the all-ones wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div       <= '0;
      r_move_tick <= 1'b0;
    end else begin
      r_div       <= r_div + 1'b1;
      r_move_tick <= &r_div;
    end
  end

  assign bus.x_coord_of_current_block = r_x;
  assign bus.y_coord_of_current_block = r_y;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.whichRAM  = r_which;
  assign bus.move_tick = r_move_tick;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.overrun   = r_overrun;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_frame_tile_scheduler.sv
// Testbench for frame_tile_scheduler: scoreboard of expected {addr, pixel} writes
// plus directed scenario tasks for the swap, overrun, collision, reset and tick cases.
module tb_frame_tile_scheduler;
  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;
  localparam int ADDR_W   = 10;
  localparam int DIV_BITS = 4;
  localparam int N_TILES  = GRID_W * GRID_H;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wr_cnt = 0;
  int   first_wr_cyc = 0;
  int   last_wr_cyc = 0;
  logic [7:0] salt = 8'h00;
  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W+7:0] mon_got;
  logic [ADDR_W+7:0] mon_exp;

  frame_tile_scheduler_if #(.ADDR_W(ADDR_W)) bus();

  frame_tile_scheduler #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W), .MOVE_DIV_BITS(DIV_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pix_fn(input logic [9:0] x, input logic [9:0] y,
                                        input logic [7:0] s);
    logic [15:0] t;
    t = 16'(x) * 16'd7 + 16'(y) * 16'd29 + 16'(s);
    return t[7:0] ^ t[15:8];
  endfunction

  // pixel generator model: combinational on the presented coordinate
  always_comb bus.pixel_in = pix_fn(bus.x_coord_of_current_block,
                                    bus.y_coord_of_current_block, salt);

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      tests_run++;
      mon_got = {bus.wr_addr, bus.wr_data};
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_write: cycle %0d addr=%0d data=%h, none expected",
                 cyc, bus.wr_addr, bus.wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          tests_failed++;
          $display("FAIL sb_write: cycle %0d got addr=%0d data=%h, expected addr=%0d data=%h",
                   cyc, mon_got[ADDR_W+7:8], mon_got[7:0], mon_exp[ADDR_W+7:8], mon_exp[7:0]);
        end
      end
      if (wr_cnt == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_scan();
    for (int y = 0; y < GRID_H; y++)
      for (int x = 0; x < GRID_W; x++)
        exp_q.push_back({10'(y * GRID_W + x), pix_fn(10'(x), 10'(y), salt)});
  endtask

  task automatic pulse_bins(output int t);
    t = cyc;
    bus.bins_valid = 1'b1;
    tick();
    bus.bins_valid = 1'b0;
  endtask

  task automatic pulse_frame(output int t);
    t = cyc;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (bus.dbg_state !== st && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (bus.dbg_state !== st) begin
      tests_failed++;
      $display("FAIL %s: state=%0d expected %0d within %0d cycles", name, bus.dbg_state, st, budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.bins_valid = 1'b0;
    bus.frame_start = 1'b0;
    tick();
    tick();
    exp_q.delete();
    reset = 1'b0;
    tick();
  endtask

  // scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    tests_run += 10;
    if (bus.wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    if (bus.wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
    if (bus.wr_data !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
    if (bus.whichRAM !== 1'b0) begin tests_failed++; $display("FAIL reset_whichRAM: got %b want 0", bus.whichRAM); end
    if (bus.move_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_move_tick: got %b want 0", bus.move_tick); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    if (bus.x_coord_of_current_block !== 10'd0) begin tests_failed++; $display("FAIL reset_x: got %0d want 0", bus.x_coord_of_current_block); end
    if (bus.y_coord_of_current_block !== 10'd0) begin tests_failed++; $display("FAIL reset_y: got %0d want 0", bus.y_coord_of_current_block); end
    if (bus.dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    tick();
    reset = 1'b0;
    wait_until(10);
  endtask

  task automatic test_full_scan();
    int t;
    salt = 8'($urandom_range(0, 255));
    push_scan();
    wr_cnt = 0;
    pulse_bins(t);
    @(negedge clk);
    tests_run += 3;
    if (bus.x_coord_of_current_block !== 10'd0 || bus.y_coord_of_current_block !== 10'd0) begin
      tests_failed++; $display("FAIL scan_first_coord: got (%0d,%0d) want (0,0)",
                               bus.x_coord_of_current_block, bus.y_coord_of_current_block);
    end
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL scan_busy: got %b want 1", bus.busy); end
    if (bus.wr_en !== 1'b0) begin tests_failed++; $display("FAIL scan_no_early_write: got %b want 0", bus.wr_en); end
    wait_until(t + 769);
    @(negedge clk);
    tests_run++;
    if (bus.dbg_state !== ST_SCAN) begin tests_failed++; $display("FAIL scan_state_last_write: got %0d want %0d", bus.dbg_state, ST_SCAN); end
    tick();
    @(negedge clk);
    tests_run += 6;
    if (bus.dbg_state !== ST_WAIT) begin tests_failed++; $display("FAIL scan_state_wait: got %0d want %0d", bus.dbg_state, ST_WAIT); end
    if (first_wr_cyc !== t + 2) begin tests_failed++; $display("FAIL scan_first_write_cycle: got %0d want %0d", first_wr_cyc, t + 2); end
    if (last_wr_cyc !== t + 769) begin tests_failed++; $display("FAIL scan_last_write_cycle: got %0d want %0d", last_wr_cyc, t + 769); end
    if (wr_cnt !== N_TILES) begin tests_failed++; $display("FAIL scan_write_count: got %0d want %0d", wr_cnt, N_TILES); end
    if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL scan_queue_drained: got %0d left want 0", exp_q.size()); end
    if (bus.whichRAM !== 1'b0) begin tests_failed++; $display("FAIL scan_no_swap: got %b want 0", bus.whichRAM); end
    repeat (50) tick();
    @(negedge clk);
    tests_run += 2;
    if (bus.whichRAM !== 1'b0) begin tests_failed++; $display("FAIL scan_hold_whichRAM: got %b want 0", bus.whichRAM); end
    if (wr_cnt !== N_TILES) begin tests_failed++; $display("FAIL scan_no_extra_write: got %0d want %0d", wr_cnt, N_TILES); end
    tick();
  endtask

  task automatic test_swap();
    int s;
    int t;
    pulse_frame(s);
    @(negedge clk);
    tests_run += 3;
    if (bus.whichRAM !== 1'b1) begin tests_failed++; $display("FAIL swap_whichRAM: got %b want 1", bus.whichRAM); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL swap_busy: got %b want 0", bus.busy); end
    if (bus.dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL swap_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    tick();
    salt = 8'($urandom_range(0, 255));
    push_scan();
    wr_cnt = 0;
    pulse_bins(t);
    wait_until(t + 400);
    @(negedge clk);
    tests_run++;
    if (bus.wr_en !== 1'b1 || bus.whichRAM !== 1'b1) begin
      tests_failed++; $display("FAIL swap_write_target: wr_en=%b whichRAM=%b want 1,1 (writes to RAM 0)", bus.wr_en, bus.whichRAM);
    end
    tick();
    wait_state(ST_WAIT, 800, "swap_second_scan_done");
    tests_run++;
    if (wr_cnt !== N_TILES) begin tests_failed++; $display("FAIL swap_second_scan_count: got %0d want %0d", wr_cnt, N_TILES); end
    pulse_frame(s);
    @(negedge clk);
    tests_run++;
    if (bus.whichRAM !== 1'b0) begin tests_failed++; $display("FAIL swap_back_whichRAM: got %b want 0", bus.whichRAM); end
    tick();
  endtask

  task automatic test_overrun();
    int t;
    int t2;
    int s;
    do_reset();
    salt = 8'($urandom_range(0, 255));
    push_scan();
    push_scan();
    wr_cnt = 0;
    pulse_bins(t);
    wait_until(t + 100);
    pulse_bins(t2);
    @(negedge clk);
    tests_run++;
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_after_second: got %b want 0", bus.overrun); end
    tick();
    wait_until(t + 200);
    pulse_bins(t2);
    @(negedge clk);
    tests_run++;
    if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_after_third: got %b want 1", bus.overrun); end
    tick();
    wait_state(ST_WAIT, 800, "overrun_first_scan_done");
    wr_cnt = 0;
    pulse_frame(s);
    @(negedge clk);
    tests_run++;
    if (bus.dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL overrun_idle_after_swap: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.dbg_state !== ST_SCAN) begin tests_failed++; $display("FAIL overrun_restart: got %0d want %0d", bus.dbg_state, ST_SCAN); end
    tick();
    wait_state(ST_WAIT, 800, "overrun_second_scan_done");
    tests_run += 4;
    if (first_wr_cyc !== s + 3) begin tests_failed++; $display("FAIL overrun_restart_first_write: got %0d want %0d", first_wr_cyc, s + 3); end
    if (wr_cnt !== N_TILES) begin tests_failed++; $display("FAIL overrun_second_count: got %0d want %0d", wr_cnt, N_TILES); end
    if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL overrun_queue_drained: got %0d want 0", exp_q.size()); end
    if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
    pulse_frame(s);
    repeat (5) tick();
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL overrun_no_third_scan: got %b want 0", bus.busy); end
    tick();
  endtask

  task automatic test_frame_start_collision();
    int t;
    int s;
    do_reset();
    salt = 8'($urandom_range(0, 255));
    push_scan();
    wr_cnt = 0;
    pulse_bins(t);
    wait_until(t + 769);
    bus.frame_start = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'd767) begin
      tests_failed++; $display("FAIL collide_last_write: wr_en=%b addr=%0d want 1,767", bus.wr_en, bus.wr_addr);
    end
    tick();
    bus.frame_start = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (bus.whichRAM !== 1'b0) begin tests_failed++; $display("FAIL collide_no_swap: got %b want 0", bus.whichRAM); end
    if (bus.dbg_state !== ST_WAIT) begin tests_failed++; $display("FAIL collide_state: got %0d want %0d", bus.dbg_state, ST_WAIT); end
    repeat (10) tick();
    pulse_frame(s);
    @(negedge clk);
    tests_run += 2;
    if (bus.whichRAM !== 1'b1) begin tests_failed++; $display("FAIL collide_late_swap: got %b want 1", bus.whichRAM); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL collide_busy: got %b want 0", bus.busy); end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int t;
    int t2;
    salt = 8'($urandom_range(0, 255));
    push_scan();
    pulse_bins(t);
    wait_until(t + 50);
    pulse_bins(t2);
    wait_until(t + 302);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'd300) begin
      tests_failed++; $display("FAIL rst_mid_at_300: wr_en=%b addr=%0d want 1,300", bus.wr_en, bus.wr_addr);
    end
    tick();
    @(negedge clk);
    tests_run += 3;
    if (bus.wr_en !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_wr_en: got %b want 0", bus.wr_en); end
    if (bus.whichRAM !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_whichRAM: got %b want 0", bus.whichRAM); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    exp_q.delete();
    tick();
    reset = 1'b0;
    wr_cnt = 0;
    repeat (40) tick();
    @(negedge clk);
    tests_run += 2;
    if (wr_cnt !== 0) begin tests_failed++; $display("FAIL rst_mid_no_writes: got %0d want 0", wr_cnt); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_pending_restart: got %b want 1'b0", bus.busy); end
    tick();
  endtask

  task automatic test_move_tick();
    int n_ticks;
    int prev;
    n_ticks = 0;
    prev = -1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (bus.move_tick === 1'b1) begin
        if (prev >= 0) begin
          tests_run++;
          if (cyc - prev !== (1 << DIV_BITS)) begin
            tests_failed++; $display("FAIL move_tick_period: got %0d want %0d", cyc - prev, 1 << DIV_BITS);
          end
        end
        prev = cyc;
        n_ticks++;
      end
    end
    tests_run++;
    if (n_ticks !== 160 / (1 << DIV_BITS)) begin
      tests_failed++; $display("FAIL move_tick_count: got %0d want %0d", n_ticks, 160 / (1 << DIV_BITS));
    end
    tick();
  endtask

  task automatic test_frame_start_idle();
    int s;
    salt = 8'($urandom_range(0, 255));
`ifdef FRAME_TILE_SCHED_AUTO_REFRESH_EN
    push_scan();
    wr_cnt = 0;
    pulse_frame(s);
    @(negedge clk);
    tests_run++;
    if (bus.dbg_state !== ST_SCAN) begin tests_failed++; $display("FAIL auto_refresh_start: got %0d want %0d", bus.dbg_state, ST_SCAN); end
    tick();
    wait_state(ST_WAIT, 800, "auto_refresh_done");
    tests_run++;
    if (wr_cnt !== N_TILES) begin tests_failed++; $display("FAIL auto_refresh_count: got %0d want %0d", wr_cnt, N_TILES); end
    pulse_frame(s);
`else
    pulse_frame(s);
    @(negedge clk);
    tests_run++;
    if (bus.dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL idle_frame_start_ignored: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    tick();
`endif
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_frame_start_final: busy=%b want 0", bus.busy); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.bins_valid = 1'b0;
    bus.frame_start = 1'b0;
    test_reset();
    test_full_scan();
    test_swap();
    test_overrun();
    test_frame_start_collision();
    test_reset_mid_scan();
    test_move_tick();
    test_frame_start_idle();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++; $display("FAIL final_queue_empty: got %0d entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
